// File: rtl/user_ram_arbiter_if.sv
// Requester-side transaction bundle for the user RAM arbiter.
// The requester drives operands and req; the arbiter returns grant, done and read data.
interface user_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned PASS_W = 16,
  parameter int unsigned CNT_W  = 4
);
  logic              req;
  logic              we;
  logic [3:0]        wmask;
  logic [ADDR_W-1:0] addr;
  logic [PASS_W-1:0] pass_wd;
  logic [CNT_W-1:0]  cnt_wd;
  logic              admin_wd;
  logic              lock_wd;
  logic              gnt;
  logic              done;
  logic [PASS_W-1:0] pass_rd;
  logic [CNT_W-1:0]  cnt_rd;
  logic              admin_rd;
  logic              lock_rd;

  modport master (
    output req, we, wmask, addr, pass_wd, cnt_wd, admin_wd, lock_wd,
    input  gnt, done, pass_rd, cnt_rd, admin_rd, lock_rd
  );

  modport slave (
    input  req, we, wmask, addr, pass_wd, cnt_wd, admin_wd, lock_wd,
    output gnt, done, pass_rd, cnt_rd, admin_rd, lock_rd
  );
endinterface

// File: rtl/user_ram_arbiter.sv
// Round-robin arbiter sharing the user RAM between the login FSM (port a) and the
// admin maintenance path (port b); one transaction at a time with read-latency wait.
module user_ram_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned PASS_W = 16,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  user_ram_arbiter_if.slave a,
  user_ram_arbiter_if.slave b,
  output logic              ram_cs,
  output logic              ram_pass_rw,
  output logic              ram_count_rw,
  output logic              ram_admin_rw,
  output logic              ram_lock_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PASS_W-1:0] ram_pass_in,
  output logic [CNT_W-1:0]  ram_count_in,
  output logic              ram_admin_in,
  output logic              ram_lock_in,
  input  logic [PASS_W-1:0] ram_pass_out,
  input  logic [CNT_W-1:0]  ram_count_out,
  input  logic              ram_admin_out,
  input  logic              ram_lock_out
);

  localparam int unsigned WAIT_W = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;      // 0 = port a, 1 = port b
  logic                last_gnt_q, last_gnt_d;
  logic                we_q, we_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [3:0]          rw_q, rw_d;            // {pass, count, admin, lock}

  logic                gnt_d, done_d, cap_d, cs_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [PASS_W-1:0]   pass_in_d;
  logic [CNT_W-1:0]    cnt_in_d;
  logic                admin_in_d, lock_in_d;

  assign ram_pass_rw  = rw_q[3];
  assign ram_count_rw = rw_q[2];
  assign ram_admin_rw = rw_q[1];
  assign ram_lock_rw  = rw_q[0];

  // Next state plus the value every registered RAM/grant output takes in that state
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    wait_cnt_d = '0;
    gnt_d      = 1'b0;
    done_d     = 1'b0;
    cap_d      = 1'b0;
    cs_d       = 1'b0;
    rw_d       = '0;
    addr_d     = '0;
    pass_in_d  = '0;
    cnt_in_d   = '0;
    admin_in_d = 1'b0;
    lock_in_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (a.req || b.req) begin
          owner_d    = (a.req && b.req) ? ~last_gnt_q : b.req;
          last_gnt_d = owner_d;
          state_d    = ACCESS;
          gnt_d      = 1'b1;
          cs_d       = 1'b1;
          if (owner_d) begin
            we_d       = b.we;
            rw_d       = b.we ? b.wmask : 4'b0000;
            addr_d     = b.addr;
            pass_in_d  = b.pass_wd;
            cnt_in_d   = b.cnt_wd;
            admin_in_d = b.admin_wd;
            lock_in_d  = b.lock_wd;
          end else begin
            we_d       = a.we;
            rw_d       = a.we ? a.wmask : 4'b0000;
            addr_d     = a.addr;
            pass_in_d  = a.pass_wd;
            cnt_in_d   = a.cnt_wd;
            admin_in_d = a.admin_wd;
            lock_in_d  = a.lock_wd;
          end
        end
      end
      ACCESS: begin
        gnt_d = 1'b1;
        if (we_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = WAIT;
          cs_d       = 1'b1;
          addr_d     = ram_addr;
          pass_in_d  = ram_pass_in;
          cnt_in_d   = ram_count_in;
          admin_in_d = ram_admin_in;
          lock_in_d  = ram_lock_in;
        end
      end
      WAIT: begin
        gnt_d = 1'b1;
        if (wait_cnt_q == WAIT_W'(RD_LAT - 1)) begin
          cap_d   = 1'b1;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          cs_d       = 1'b1;
          addr_d     = ram_addr;
          pass_in_d  = ram_pass_in;
          cnt_in_d   = ram_count_in;
          admin_in_d = ram_admin_in;
          lock_in_d  = ram_lock_in;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, registered outputs and per-port read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_gnt_q   <= 1'b1;
      we_q         <= 1'b0;
      wait_cnt_q   <= '0;
      rw_q         <= '0;
      ram_cs       <= 1'b0;
      ram_addr     <= '0;
      ram_pass_in  <= '0;
      ram_count_in <= '0;
      ram_admin_in <= 1'b0;
      ram_lock_in  <= 1'b0;
      a.gnt        <= 1'b0;
      b.gnt        <= 1'b0;
      a.done       <= 1'b0;
      b.done       <= 1'b0;
      a.pass_rd    <= '0;
      a.cnt_rd     <= '0;
      a.admin_rd   <= 1'b0;
      a.lock_rd    <= 1'b0;
      b.pass_rd    <= '0;
      b.cnt_rd     <= '0;
      b.admin_rd   <= 1'b0;
      b.lock_rd    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_gnt_q   <= last_gnt_d;
      we_q         <= we_d;
      wait_cnt_q   <= wait_cnt_d;
      rw_q         <= rw_d;
      ram_cs       <= cs_d;
      ram_addr     <= addr_d;
      ram_pass_in  <= pass_in_d;
      ram_count_in <= cnt_in_d;
      ram_admin_in <= admin_in_d;
      ram_lock_in  <= lock_in_d;
      a.gnt        <= gnt_d & ~owner_d;
      b.gnt        <= gnt_d & owner_d;
      a.done       <= done_d & ~owner_d;
      b.done       <= done_d & owner_d;
      if (cap_d && !owner_q) begin
        a.pass_rd  <= ram_pass_out;
        a.cnt_rd   <= ram_count_out;
        a.admin_rd <= ram_admin_out;
        a.lock_rd  <= ram_lock_out;
      end
      if (cap_d && owner_q) begin
        b.pass_rd  <= ram_pass_out;
        b.cnt_rd   <= ram_count_out;
        b.admin_rd <= ram_admin_out;
        b.lock_rd  <= ram_lock_out;
      end
    end
  end

endmodule

// File: tb/tb_user_ram_arbiter.sv
// Randomized bench for user_ram_arbiter: a shadow memory and a round-robin
// bookkeeping model predict grants, RAM pin activity, done timing and read data.
module tb_user_ram_arbiter;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned PASS_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned RD_LAT = 1;

  typedef struct {
    bit               we;
    logic [3:0]       mask;
    logic [ADDR_W-1:0] addr;
    logic [PASS_W-1:0] pass;
    logic [CNT_W-1:0]  cnt;
    logic             admin;
    logic             lock;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  user_ram_arbiter_if #(.ADDR_W(ADDR_W), .PASS_W(PASS_W), .CNT_W(CNT_W)) ia ();
  user_ram_arbiter_if #(.ADDR_W(ADDR_W), .PASS_W(PASS_W), .CNT_W(CNT_W)) ib ();

  logic              ram_cs, ram_pass_rw, ram_count_rw, ram_admin_rw, ram_lock_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [PASS_W-1:0] ram_pass_in, ram_pass_out;
  logic [CNT_W-1:0]  ram_count_in, ram_count_out;
  logic              ram_admin_in, ram_admin_out, ram_lock_in, ram_lock_out;

  user_ram_arbiter #(.ADDR_W(ADDR_W), .PASS_W(PASS_W), .CNT_W(CNT_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .a(ia), .b(ib),
    .ram_cs(ram_cs), .ram_pass_rw(ram_pass_rw), .ram_count_rw(ram_count_rw),
    .ram_admin_rw(ram_admin_rw), .ram_lock_rw(ram_lock_rw), .ram_addr(ram_addr),
    .ram_pass_in(ram_pass_in), .ram_count_in(ram_count_in),
    .ram_admin_in(ram_admin_in), .ram_lock_in(ram_lock_in),
    .ram_pass_out(ram_pass_out), .ram_count_out(ram_count_out),
    .ram_admin_out(ram_admin_out), .ram_lock_out(ram_lock_out)
  );

  // RAM with one-cycle registered read and per-field write strobes
  logic [PASS_W-1:0] m_pass  [0:4095];
  logic [CNT_W-1:0]  m_cnt   [0:4095];
  logic              m_admin [0:4095];
  logic              m_lock  [0:4095];
  always @(posedge clk) begin
    ram_pass_out  <= m_pass[ram_addr];
    ram_count_out <= m_cnt[ram_addr];
    ram_admin_out <= m_admin[ram_addr];
    ram_lock_out  <= m_lock[ram_addr];
    if (ram_cs && ram_pass_rw)  m_pass[ram_addr]  <= ram_pass_in;
    if (ram_cs && ram_count_rw) m_cnt[ram_addr]   <= ram_count_in;
    if (ram_cs && ram_admin_rw) m_admin[ram_addr] <= ram_admin_in;
    if (ram_cs && ram_lock_rw)  m_lock[ram_addr]  <= ram_lock_in;
  end

  // Reference model state
  logic [PASS_W-1:0] sh_pass  [0:4095];
  logic [CNT_W-1:0]  sh_cnt   [0:4095];
  logic              sh_admin [0:4095];
  logic              sh_lock  [0:4095];
  logic [21:0]       exp_rd [2];
  op_t               pend [2];
  bit                last;
  int                n_vec = 0;
  int                n_err = 0;
  bit                mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic gnt_of(input bit p);
    return p ? ib.gnt : ia.gnt;
  endfunction

  function automatic logic done_of(input bit p);
    return p ? ib.done : ia.done;
  endfunction

  function automatic logic [21:0] rd_of(input bit p);
    return p ? {ib.pass_rd, ib.cnt_rd, ib.admin_rd, ib.lock_rd}
             : {ia.pass_rd, ia.cnt_rd, ia.admin_rd, ia.lock_rd};
  endfunction

  function automatic logic [3:0] rw_vec();
    return {ram_pass_rw, ram_count_rw, ram_admin_rw, ram_lock_rw};
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.we    = 1'($urandom_range(0, 1));
    o.mask  = 4'($urandom);
    o.addr  = ADDR_W'($urandom_range(0, 15));
    o.pass  = PASS_W'($urandom);
    o.cnt   = CNT_W'($urandom);
    o.admin = 1'($urandom);
    o.lock  = 1'($urandom);
    return o;
  endfunction

  task automatic drive_port(input bit p, input op_t o, input logic req);
    if (p) begin
      ib.we = o.we; ib.wmask = o.mask; ib.addr = o.addr; ib.pass_wd = o.pass;
      ib.cnt_wd = o.cnt; ib.admin_wd = o.admin; ib.lock_wd = o.lock; ib.req = req;
    end else begin
      ia.we = o.we; ia.wmask = o.mask; ia.addr = o.addr; ia.pass_wd = o.pass;
      ia.cnt_wd = o.cnt; ia.admin_wd = o.admin; ia.lock_wd = o.lock; ia.req = req;
    end
  endtask

  task automatic post(input bit p, input op_t o);
    pend[p] = o;
    drive_port(p, o, 1'b1);
  endtask

  task automatic model_reset();
    last = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic do_reset();
    op_t z;
    z = '{default: '0};
    drive_port(1'b0, z, 1'b0);
    drive_port(1'b1, z, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Serve the pending op of port p; DUT must be in IDLE with p's request visible.
  task automatic serve(input bit p, input bit drop);
    op_t o;
    o = pend[p];
    @(posedge clk); #1;
    check("acc_gnt", 32'(gnt_of(p)), 32'd1);
    check("acc_gnt_other", 32'(gnt_of(!p)), 32'd0);
    check("acc_cs", 32'(ram_cs), 32'd1);
    check("acc_addr", 32'(ram_addr), 32'(o.addr));
    check("acc_rw", 32'(rw_vec()), 32'(o.we ? o.mask : 4'b0000));
    check("acc_wdata", {4'b0, ram_pass_in, ram_count_in, ram_admin_in, ram_lock_in},
          {4'b0, o.pass, o.cnt, o.admin, o.lock});
    check("acc_done", 32'(done_of(p)), 32'd0);
    if (drop) drive_port(p, rand_op(), 1'b0);
    if (!o.we) begin
      repeat (RD_LAT) begin
        @(posedge clk); #1;
        check("wait_cs", 32'(ram_cs), 32'd1);
        check("wait_rw", 32'(rw_vec()), 32'd0);
        check("wait_addr", 32'(ram_addr), 32'(o.addr));
        check("wait_gnt", 32'(gnt_of(p)), 32'd1);
        check("wait_done", 32'(done_of(p)), 32'd0);
      end
    end
    @(posedge clk); #1;
    check("done_pulse", 32'(done_of(p)), 32'd1);
    check("done_other", 32'(done_of(!p)), 32'd0);
    check("done_gnt", {30'b0, gnt_of(p), gnt_of(!p)}, 32'd2);
    check("done_cs", 32'(ram_cs), 32'd0);
    check("done_rw", 32'(rw_vec()), 32'd0);
    check("done_addr", 32'(ram_addr), 32'd0);
    check("done_wdata", 32'(ram_pass_in), 32'd0);
    if (o.we) begin
      if (o.mask[3]) sh_pass[o.addr]  = o.pass;
      if (o.mask[2]) sh_cnt[o.addr]   = o.cnt;
      if (o.mask[1]) sh_admin[o.addr] = o.admin;
      if (o.mask[0]) sh_lock[o.addr]  = o.lock;
    end else begin
      exp_rd[p] = {sh_pass[o.addr], sh_cnt[o.addr], sh_admin[o.addr], sh_lock[o.addr]};
    end
    check(p ? "b_rd" : "a_rd", 32'(rd_of(p)), 32'(exp_rd[p]));
    check(p ? "a_rd_kept" : "b_rd_kept", 32'(rd_of(!p)), 32'(exp_rd[!p]));
    if (p) ib.req = 1'b0; else ia.req = 1'b0;
    last = p;
    @(posedge clk); #1;
    check("idle_gnt", {30'b0, ia.gnt, ib.gnt}, 32'd0);
    check("idle_done", {30'b0, ia.done, ib.done}, 32'd0);
    check("idle_cs", 32'(ram_cs), 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) check("gnt_mutex", 32'(ia.gnt & ib.gnt), 32'd0);
  end

  initial begin
    op_t o;
    bit  w;
    bit  drop;
    int  mode;
    for (int i = 0; i < 4096; i++) begin
      m_pass[i] = '0; m_cnt[i] = '0; m_admin[i] = 1'b0; m_lock[i] = 1'b0;
      sh_pass[i] = '0; sh_cnt[i] = '0; sh_admin[i] = 1'b0; sh_lock[i] = 1'b0;
    end
    o = '{default: '0};
    drive_port(1'b0, o, 1'b0);
    drive_port(1'b1, o, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt_done", {28'b0, ia.gnt, ib.gnt, ia.done, ib.done}, 32'd0);
    check("rst_cs_rw", {27'b0, ram_cs, rw_vec()}, 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_a_rd", 32'(rd_of(1'b0)), 32'd0);
    check("rst_b_rd", 32'(rd_of(1'b1)), 32'd0);
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Full-mask write then read back on port a
    o = '{we: 1'b1, mask: 4'b1111, addr: 12'h005, pass: 16'h1234, cnt: 4'h3, admin: 1'b1, lock: 1'b0};
    post(1'b0, o); serve(1'b0, 1'b0);
    o.we = 1'b0;
    post(1'b0, o); serve(1'b0, 1'b0);
    check("dir_read_1234", 32'(ia.pass_rd), 32'h1234);

    // Both ports held after reset: grants alternate starting with a
    do_reset();
    post(1'b0, rand_op());
    post(1'b1, rand_op());
    for (int k = 0; k < 4; k++) begin
      w = 1'(k % 2);
      check("rr_order", 32'(!last), 32'(w));
      serve(w, 1'b0);
      post(w, rand_op());
    end
    serve(1'b0, 1'b0);
    serve(1'b1, 1'b0);

    // Lock-only write from b, then read back
    o = '{we: 1'b1, mask: 4'b0001, addr: 12'h00A, pass: 16'hBEEF, cnt: 4'hF, admin: 1'b1, lock: 1'b1};
    post(1'b1, o); serve(1'b1, 1'b0);
    o.we = 1'b0;
    post(1'b1, o); serve(1'b1, 1'b0);
    check("lock_only", 32'(ib.lock_rd), 32'd1);

    // Mask-zero write is a no-op that still completes
    o = '{we: 1'b1, mask: 4'b0000, addr: 12'h005, pass: 16'hFFFF, cnt: 4'hF, admin: 1'b0, lock: 1'b1};
    post(1'b0, o); serve(1'b0, 1'b0);

    // Reset during the wait cycle of an a read aborts it
    o = '{we: 1'b0, mask: 4'b0000, addr: 12'h005, pass: '0, cnt: '0, admin: 1'b0, lock: 1'b0};
    post(1'b0, o);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_wait", 32'(ram_cs), 32'd1);
    rst = 1'b1;
    ia.req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("abort_no_done", 32'(ia.done), 32'd0);
    check("abort_cs", 32'(ram_cs), 32'd0);
    check("abort_gnt", 32'(ia.gnt), 32'd0);
    post(1'b0, o); serve(1'b0, 1'b0);

    // Randomized mix of single and contending requests
    for (int i = 0; i < 150; i++) begin
      mode = $urandom_range(0, 2);
      drop = ($urandom_range(0, 3) == 0);
      if (mode < 2) begin
        post(1'(mode), rand_op());
        serve(1'(mode), drop);
      end else begin
        w = !last;
        post(1'b0, rand_op());
        post(1'b1, rand_op());
        serve(w, drop);
        serve(!w, 1'b0);
      end
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
